// File: rtl/double_framebuffer.sv
// ---------------------------------------------------------------------------
// double_framebuffer
//   Two-bank channel framebuffer for the LED board chain. The writer fills
//   the back bank while the display reader scans the front bank. A swap
//   request is held until the reader signals a frame boundary. At that edge
//   the banks exchange roles.
//
//   Optional feature macro: FRAMEBUFFER_COPY_ON_SWAP_EN
//     When defined, each swap is followed by a COPY phase. During COPY the new
//     front bank (data and metadata) is copied into the new back bank, one
//     word per cycle, and writes are blocked (o_busy=1). The writer can then
//     start from the frame it just presented.
//
// Ports
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_wen/i_waddr/i_wdata  back-bank write port
//   i_time/i_type        back-bank metadata, captured with every accepted write
//   i_swap               request to present the back bank
//   i_frame_end          frame boundary pulse from the display reader
//   i_raddr              front-bank read address
//   o_rdata              front[i_raddr], one cycle latency (0 if out of range)
//   o_time/o_type        front-bank metadata
//   o_bank               index of the front bank
//   o_busy               writes blocked (copy phase)
//   o_swap_done          one-cycle pulse after the swap edge
// ---------------------------------------------------------------------------
module double_framebuffer #(
   parameter  int c_ledboards = 30,
   parameter  int c_bpc       = 12,
   parameter  int c_max_time  = 1024,
   parameter  int c_max_type  = 64,
   localparam int c_time_w    = $clog2(c_max_time),
   localparam int c_type_w    = $clog2(c_max_type),
   localparam int c_channels  = c_ledboards * 32,
   localparam int c_addr_w    = $clog2(c_channels)
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_wen,
   input  logic [c_addr_w-1:0] i_waddr,
   input  logic [c_bpc-1:0]    i_wdata,
   input  logic [c_time_w-1:0] i_time,
   input  logic [c_type_w-1:0] i_type,
   input  logic                i_swap,
   input  logic                i_frame_end,
   input  logic [c_addr_w-1:0] i_raddr,
   output logic [c_bpc-1:0]    o_rdata,
   output logic [c_time_w-1:0] o_time,
   output logic [c_type_w-1:0] o_type,
   output logic                o_bank,
   output logic                o_busy,
   output logic                o_swap_done
);

   // One extra bit so a power-of-two channel count still compares correctly.
   localparam logic [c_addr_w:0] c_chan_l = (c_addr_w+1)'(c_channels);

`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
   localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);
   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COPY} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_PENDING} state_t;
`endif

   state_t              r_state;
   logic                r_bank;
   logic                r_swap_done;
   logic [c_bpc-1:0]    r_rdata;
   logic [c_time_w-1:0] r_otime;
   logic [c_type_w-1:0] r_otype;

   logic [c_bpc-1:0]    r_mem  [2][c_channels];
   logic [c_time_w-1:0] r_time [2];
   logic [c_type_w-1:0] r_type [2];

   logic w_back, w_busy, w_wr_ok, w_rd_ok, w_wacc, w_swap, w_bank_nxt, w_fwd;

`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
   logic                r_busy;
   logic                r_pend;   // swap request seen during COPY
   logic [c_addr_w-1:0] r_cnt;
   logic                w_cpy;
   assign w_busy = r_busy;
   assign w_cpy  = i_rstn & (r_state == S_COPY);
`else
   assign w_busy = 1'b0;
`endif

   assign w_back     = ~r_bank;
   assign w_wr_ok    = {1'b0, i_waddr} < c_chan_l;
   assign w_rd_ok    = {1'b0, i_raddr} < c_chan_l;
   assign w_wacc     = i_rstn & i_wen & ~w_busy & w_wr_ok;
   // IDLE swaps immediately when request and frame end coincide.
   assign w_swap     = i_rstn & i_frame_end &
                       (((r_state == S_IDLE) & i_swap) | (r_state == S_PENDING));
   assign w_bank_nxt = r_bank ^ w_swap;
   // A write on the swap edge targets the bank becoming front, so the
   // registered read must see it.
   assign w_fwd      = w_wacc & w_swap & (i_waddr == i_raddr);

   // Bank storage: intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (w_wacc) r_mem[w_back][i_waddr] <= i_wdata;
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
      if (w_cpy) r_mem[w_back][r_cnt] <= r_mem[r_bank][r_cnt];
`endif
   end

   // Per-bank metadata.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_time[0] <= '0;
         r_time[1] <= '0;
         r_type[0] <= '0;
         r_type[1] <= '0;
      end else begin
         if (w_wacc) begin
            r_time[w_back] <= i_time;
            r_type[w_back] <= i_type;
         end
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
         if (w_cpy && r_cnt == '0) begin
            r_time[w_back] <= r_time[r_bank];
            r_type[w_back] <= r_type[r_bank];
         end
`endif
      end
   end

   // Front-bank read path, based on the bank that is front after this edge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_rdata <= '0;
         r_otime <= '0;
         r_otype <= '0;
      end else begin
         if (!w_rd_ok)   r_rdata <= '0;
         else if (w_fwd) r_rdata <= i_wdata;
         else            r_rdata <= r_mem[w_bank_nxt][i_raddr];
         r_otime <= (w_wacc & w_swap) ? i_time : r_time[w_bank_nxt];
         r_otype <= (w_wacc & w_swap) ? i_type : r_type[w_bank_nxt];
      end
   end

   // Swap control FSM.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= S_IDLE;
         r_bank      <= 1'b0;
         r_swap_done <= 1'b0;
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
         r_busy      <= 1'b0;
         r_pend      <= 1'b0;
         r_cnt       <= '0;
`endif
      end else begin
         r_swap_done <= w_swap;
         r_bank      <= w_bank_nxt;
         if (w_swap) begin
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
            r_state <= S_COPY;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
`else
            r_state <= S_IDLE;
`endif
         end else begin
            case (r_state)
               S_IDLE:    if (i_swap) r_state <= S_PENDING;
               S_PENDING: r_state <= S_PENDING;   // extra requests merge
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
               S_COPY: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (i_swap) r_pend <= 1'b1;
                  if (r_cnt == c_last) begin
                     r_state <= (r_pend | i_swap) ? S_PENDING : S_IDLE;
                     r_busy  <= 1'b0;
                     r_pend  <= 1'b0;
                  end
               end
`endif
               default:   r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_rdata     = r_rdata;
   assign o_time      = r_otime;
   assign o_type      = r_otype;
   assign o_bank      = r_bank;
   assign o_busy      = w_busy;
   assign o_swap_done = r_swap_done;

endmodule

// File: tb/tb_double_framebuffer.sv
// Scoreboard bench for double_framebuffer (default parameters). A driver
// applies one input vector per cycle and pushes the reference model's
// expected outputs. A monitor pops one entry and compares it after every
// rising edge.
module tb_double_framebuffer;
   localparam int C = 960, BPC = 12, TW = 10, YW = 6, AW = 10;

   logic          clk = 1'b0;
   logic          rstn, wen, swap, fe;
   logic [AW-1:0] waddr, raddr;
   logic [BPC-1:0] wdata;
   logic [TW-1:0] tim;
   logic [YW-1:0] typ;
   logic [BPC-1:0] o_rdata;
   logic [TW-1:0] o_time;
   logic [YW-1:0] o_type;
   logic          o_bank, o_busy, o_swap_done;

   always #5 clk = ~clk;

   double_framebuffer dut (
      .i_clk(clk), .i_rstn(rstn), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
      .i_time(tim), .i_type(typ), .i_swap(swap), .i_frame_end(fe), .i_raddr(raddr),
      .o_rdata(o_rdata), .o_time(o_time), .o_type(o_type), .o_bank(o_bank),
      .o_busy(o_busy), .o_swap_done(o_swap_done)
   );

   typedef struct packed {
      logic [BPC-1:0] rdata;
      logic [TW-1:0]  t;
      logic [YW-1:0]  y;
      logic           bank, busy, sd;
   } exp_t;

   exp_t q[$];
   exp_t m_exp, m_got;
   int   vectors = 0, miscompares = 0;

   // Reference model: bank contents as plain arrays, plus the
   // swap request flag and the number of copy cycles remaining.
   int unsigned mem [2][C];
   int unsigned mt [2], my [2];
   int          mbank = 0, mpend = 0, mleft = 0;

   task automatic model_step();
      exp_t e;
      bit   acc, sw;
      int   back, k;
      e = '0;
      if (!rstn) begin
         mbank = 0; mpend = 0; mleft = 0;
         mt[0] = 0; mt[1] = 0; my[0] = 0; my[1] = 0;
      end else begin
         back = 1 - mbank;
         acc  = wen && (mleft == 0) && (int'(waddr) < C);
         sw   = (mleft == 0) && fe && (mpend != 0 || swap);
         if (mleft > 0) begin
            k = C - mleft;
            mem[back][k] = mem[mbank][k];
            if (k == 0) begin mt[back] = mt[mbank]; my[back] = my[mbank]; end
            mleft = mleft - 1;
            if (swap) mpend = 1;
         end else if (swap && !sw) mpend = 1;
         if (acc) begin
            mem[back][waddr] = int'(wdata);
            mt[back] = int'(tim);
            my[back] = int'(typ);
         end
         if (sw) begin
            mbank = 1 - mbank;
            mpend = 0;
`ifdef FRAMEBUFFER_COPY_ON_SWAP_EN
            mleft = C;
`endif
         end
         e.rdata = (int'(raddr) < C) ? BPC'(mem[mbank][raddr]) : '0;
         e.t     = TW'(mt[mbank]);
         e.y     = YW'(my[mbank]);
         e.bank  = (mbank != 0);
         e.busy  = (mleft > 0);
         e.sd    = sw;
      end
      q.push_back(e);
   endtask

   task automatic drive(input bit r, input bit w, input int wa, input int wd,
                        input int t, input int y, input bit s, input bit f,
                        input int ra);
      @(negedge clk);
      rstn = r; wen = w; waddr = AW'(wa); wdata = BPC'(wd);
      tim = TW'(t); typ = YW'(y); swap = s; fe = f; raddr = AW'(ra);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 1023));
   endtask

   // Monitor
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            m_exp = q.pop_front();
            m_got = {o_rdata, o_time, o_type, o_bank, o_busy, o_swap_done};
            vectors++;
            if (m_got !== m_exp) begin
               miscompares++;
               $display("FAIL out@%0t rdata %h/%h time %0d/%0d type %0d/%0d bank %0d/%0d busy %0d/%0d swap_done %0d/%0d (got/exp)",
                        $time, m_got.rdata, m_exp.rdata, m_got.t, m_exp.t, m_got.y, m_exp.y,
                        m_got.bank, m_exp.bank, m_got.busy, m_exp.busy, m_got.sd, m_exp.sd);
            end
         end
      end
   end

   initial begin
      rstn = 0; wen = 0; waddr = '0; wdata = '0; tim = '0; typ = '0;
      swap = 0; fe = 0; raddr = '0;
      // Reset with busy inputs: everything must read zero, writes dropped.
      for (int i = 0; i < 4; i++)
         drive(0, 1, $urandom_range(0, C-1), $urandom, $urandom, $urandom, 1, 1,
               $urandom_range(0, 1023));
      // Fill back bank 1, present it, fill bank 0; reads stay out of range.
      for (int a = 0; a < C; a++)
         drive(1, 1, a, $urandom, $urandom, $urandom, 0, 0, C + (a % 64));
      drive(1, 0, 0, 0, 0, 0, 1, 1, C);
      for (int i = 0; i < C + 2; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, C + (i % 64));
      for (int a = 0; a < C; a++)
         drive(1, 1, a, $urandom, $urandom, $urandom, 0, 0, C + (a % 64));
      // Write 5=0x7FF, swap with coincident frame end, read it back.
      drive(1, 1, 5, 'h7FF, 100, 7, 0, 0, 5);
      drive(1, 0, 0, 0, 0, 0, 1, 1, 5);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 5);
      idle(C + 4);
      // Swap request plus three merged requests, frame end 10 cycles later.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 7);
      for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 0, 0, (i % 3) == 0, 0, 7);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 7);
      idle(C + 4);
      // Out-of-range write/read.
      drive(1, 1, C, 'hABC, 1, 1, 0, 0, C);
      drive(1, 0, 0, 0, 0, 0, 0, 0, C);
      // Metadata follows the swap.
      drive(1, 1, 3, 'h123, 100, 7, 0, 0, 3);
      drive(1, 0, 0, 0, 0, 0, 1, 0, 3);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 3);
      idle(C + 4);
      // Reset while pending, then frame ends must not swap.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 9);
      idle(3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 9);
      // Reset right after a swap (mid-copy when copy is enabled).
      drive(1, 0, 0, 0, 0, 0, 1, 1, 9);
      idle(6);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9);
      idle(5);
      // Random traffic.
      for (int i = 0; i < 4000; i++)
         drive($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1023), $urandom, $urandom, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 1023));
      idle(2);
      @(posedge clk);
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, 0 required", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
